// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative EX-stage multiply/divide unit producing hi/lo
//
// Optional build macro: SIGNED_MULDIV_EN (signed operations selected by op[1]).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        launch request, sampled only in IDLE
//   op[1:0]      op[0]: 0=multiply 1=divide; op[1]: signed (SIGNED_MULDIV_EN only)
//   a, b         multiplicand/dividend, multiplier/divisor; latched on accepted start
//   flush        aborts an in-flight operation
//   busy         high while running
//   done         one-cycle pulse when hi/lo update
//   hi, lo       multiply: upper/lower product; divide: remainder/quotient
//   div_by_zero  completed divide had b == 0

module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Working accumulators, kept apart from hi/lo so partial values stay hidden.
    // Multiply: {acc_hi, acc_lo} is the shifting product, acc_lo starts as multiplier.
    // Divide:   acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_lat;    // raw dividend, reported as remainder on divide-by-zero
    logic             is_div;
    logic             b_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_MULDIV_EN
    logic a_neg;
    logic b_neg;
    logic neg_res;  // product / quotient must be negated
    logic neg_rem;  // remainder follows the sign of the dividend

    always_comb begin
        a_neg = op[1] & a[WIDTH-1];
        b_neg = op[1] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end
`else
    logic unused_op_sign;

    assign unused_op_sign = op[1];
    assign a_mag          = a;
    assign b_mag          = b;
`endif

    // One iteration of either algorithm.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;  // partial remainder after shifting in the next dividend bit
    logic             div_ok;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            mul_sum = {1'b0, acc_hi} + {1'b0, opnd};
        end
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd});
        if (is_div) begin
            // The true difference is below the divisor, so WIDTH bits hold it exactly.
            nxt_hi = div_ok ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ok};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Final result selection, including sign fix-up and divide-by-zero override.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod = {acc_hi, acc_lo};
        quo  = acc_lo;
        rem  = acc_hi;
`ifdef SIGNED_MULDIV_EN
        if (neg_res) begin
            prod = -{acc_hi, acc_lo};
            quo  = -acc_lo;
        end
        if (neg_rem) begin
            rem = -acc_hi;
        end
`endif
        if (is_div) begin
            if (b_zero) begin
                fin_lo = '1;
                fin_hi = a_lat;
            end else begin
                fin_lo = quo;
                fin_hi = rem;
            end
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            a_lat       <= '0;
            is_div      <= 1'b0;
            b_zero      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        is_div      <= op[0];
                        b_zero      <= (b == '0);
                        a_lat       <= a;
                        acc_hi      <= '0;
                        div_by_zero <= 1'b0;
                        if (op[0]) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                        end
`ifdef SIGNED_MULDIV_EN
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
`endif
                    end
                end

                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        // All iterations done; this edge commits the fixed-up result.
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        hi          <= fin_hi;
                        lo          <= fin_lo;
                        div_by_zero <= is_div & b_zero;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit

module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int pulses   = 0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    // Returns just after the accepting edge E0, with n = 0.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = 32'hdeadbeef;
        b     = 32'h0badf00d;
        n     = 0;
    endtask

    task automatic wait_done(input string tag);
        while (done !== 1'b1 && n < 200) step();
        chk(tag, 64'(n), 64'(33));
    endtask

    task automatic count_pulses(input string tag);
        pulses = 0;
        repeat (40) begin
            step();
            if (done === 1'b1) pulses++;
        end
        chk(tag, 64'(pulses), 64'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        rst = 1'b0;

        // Unsigned multiply of all-ones operands with explicit latency checks.
        issue(2'b00, 32'hffffffff, 32'hffffffff);
        step();
        chk("mul_busy_c1", 64'(busy), 64'(1));
        repeat (31) step();
        chk("mul_busy_c32", 64'(busy), 64'(1));
        chk("mul_done_c32", 64'(done), 64'(0));
        step();
        chk("mul_done_c33", 64'(done), 64'(1));
        chk("mul_busy_c33", 64'(busy), 64'(0));
        chk("mul_ff_hi", 64'(hi), 64'(32'hfffffffe));
        chk("mul_ff_lo", 64'(lo), 64'(32'h00000001));
        // start while in DONE must be ignored.
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd1;
        b     = 32'd1;
        step();
        start = 1'b0;
        chk("done_pulse_width", 64'(done), 64'(0));
        step();
        chk("start_in_done_ignored", 64'(busy), 64'(0));
        chk("mul_ff_hi_hold", 64'(hi), 64'(32'hfffffffe));

        // Unsigned divides, including divide by zero.
        issue(2'b01, 32'd100, 32'd7);
        wait_done("div_latency");
        chk("div_lo", 64'(lo), 64'(14));
        chk("div_hi", 64'(hi), 64'(2));
        chk("div_dbz", 64'(div_by_zero), 64'(0));
        issue(2'b01, 32'h1234, 32'd0);
        wait_done("dbz_latency");
        chk("dbz_lo", 64'(lo), 64'(32'hffffffff));
        chk("dbz_hi", 64'(hi), 64'(32'h1234));
        chk("dbz_flag", 64'(div_by_zero), 64'(1));
        step();
        chk("dbz_flag_hold", 64'(div_by_zero), 64'(1));
        issue(2'b01, 32'd47, 32'd7);
        chk("dbz_cleared_on_start", 64'(div_by_zero), 64'(0));
        wait_done("div47_latency");
        chk("div47_lo", 64'(lo), 64'(6));
        chk("div47_hi", 64'(hi), 64'(5));

        // Flush mid-run keeps the previous result and produces no done.
        issue(2'b00, 32'd3, 32'd4);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_done", 64'(done), 64'(0));
        chk("flush_hi", 64'(hi), 64'(5));
        chk("flush_lo", 64'(lo), 64'(6));
        count_pulses("flush_no_done");
        // Flush in IDLE beats a simultaneous start.
        @(negedge clk);
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_start_busy", 64'(busy), 64'(0));
        count_pulses("idle_flush_no_done");
        chk("idle_flush_lo", 64'(lo), 64'(6));

        // start during RUN is ignored.
        issue(2'b00, 32'd2, 32'd3);
        repeat (5) step();
        op    = 2'b00;
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignore_start_latency");
        chk("ignore_start_hi", 64'(hi), 64'(0));
        chk("ignore_start_lo", 64'(lo), 64'(6));

        // Reset mid-run.
        issue(2'b00, 32'd2, 32'd3);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_hi", 64'(hi), 64'(0));
        chk("midrst_lo", 64'(lo), 64'(0));
        count_pulses("midrst_no_done");

        // Further unsigned patterns.
        issue(2'b00, 32'h12345678, 32'h10);
        wait_done("mul_shift_latency");
        chk("mul_shift_hi", 64'(hi), 64'(32'h1));
        chk("mul_shift_lo", 64'(lo), 64'(32'h23456780));
        issue(2'b01, 32'd5, 32'd9);
        wait_done("div_small_latency");
        chk("div_small_lo", 64'(lo), 64'(0));
        chk("div_small_hi", 64'(hi), 64'(5));
        issue(2'b01, 32'hffffffff, 32'h10);
        wait_done("div_big_latency");
        chk("div_big_lo", 64'(lo), 64'(32'h0fffffff));
        chk("div_big_hi", 64'(hi), 64'(32'hf));

`ifdef SIGNED_MULDIV_EN
        issue(2'b10, 32'hfffffff9, 32'd3);
        wait_done("smul_latency");
        chk("smul_hi", 64'(hi), 64'(32'hffffffff));
        chk("smul_lo", 64'(lo), 64'(32'hffffffeb));
        issue(2'b11, 32'hfffffff9, 32'd2);
        wait_done("sdiv_latency");
        chk("sdiv_lo", 64'(lo), 64'(32'hfffffffd));
        chk("sdiv_hi", 64'(hi), 64'(32'hffffffff));
        issue(2'b11, 32'h80000000, 32'hffffffff);
        wait_done("sdiv_ovf_latency");
        chk("sdiv_ovf_lo", 64'(lo), 64'(32'h80000000));
        chk("sdiv_ovf_hi", 64'(hi), 64'(0));
`else
        issue(2'b11, 32'hfffffff9, 32'd2);
        wait_done("udiv_op1_latency");
        chk("udiv_op1_lo", 64'(lo), 64'(32'h7ffffffc));
        chk("udiv_op1_hi", 64'(hi), 64'(1));
        issue(2'b10, 32'hfffffff9, 32'd3);
        wait_done("umul_op1_latency");
        chk("umul_op1_hi", 64'(hi), 64'(32'h2));
        chk("umul_op1_lo", 64'(lo), 64'(32'hffffffeb));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
